instruction_fetch: RTL

Fetch stage of the single-issue RISC-V core. Holds the program counter, issues one instruction-memory read at a time over a valid/ready request channel, and captures the returned word into a one-entry output register that feeds decode and the immediate generator. Accepts redirects from the branch/jump resolution logic (JAL, JALR, BEQ/BNE targets) and flushes any stale fetch.

---
 rtl/instruction_fetch.sv | 109 ++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - RISC-V fetch stage: PC, single-outstanding imem request, one-entry output register
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state;
  logic [31:0] fetch_pc;
  logic        discard;
  logic        consume;
  logic        req_fire;
  logic [31:0] redirect_aligned;

  assign consume          = if_valid & ~stall;
  assign imem_req_valid   = (state == REQ) & ~redirect_valid & (~if_valid | ~stall);
  assign imem_addr        = fetch_pc;
  assign req_fire         = imem_req_valid & imem_req_ready;
  assign redirect_aligned = redirect_pc & ~32'd3;
  assign if_pc_plus4      = if_pc + 32'd4;

  // Fetch FSM, program counter, stale-response discard flag and output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      fetch_pc       <= RESET_PC;
      discard        <= 1'b0;
      if_valid       <= 1'b0;
      if_instruction <= NOP;
      if_pc          <= RESET_PC;
    end else begin
      // Decode took the held instruction; a capture below overrides this
      if (consume) begin
        if_valid <= 1'b0;
      end

      if (redirect_valid) begin
        // Redirect wins over everything; no request goes out this cycle
        fetch_pc <= redirect_aligned;
        if_valid <= 1'b0;
        if (state == WAIT) begin
          if (imem_resp_valid) begin
            // The in-flight response arrives now and is simply dropped
            discard <= 1'b0;
            state   <= REQ;
          end else begin
            // Response still pending: mark it stale and keep waiting for it
            discard <= 1'b1;
            state   <= WAIT;
          end
        end else begin
          discard <= 1'b0;
          state   <= REQ;
        end
      end else begin
        case (state)
          IDLE: begin
            state <= REQ;
          end
          REQ: begin
            // fetch_pc keeps naming the outstanding address until it returns
            if (req_fire) begin
              state <= WAIT;
            end
          end
          WAIT: begin
            if (imem_resp_valid) begin
              if (discard) begin
                // Stale word from before a redirect; fetch_pc already holds the target
                discard <= 1'b0;
              end else begin
                if_instruction <= imem_resp_data;
                if_pc          <= fetch_pc;
                if_valid       <= 1'b1;
                fetch_pc       <= fetch_pc + 32'd4;
              end
              state <= REQ;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
